// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, stack opcodes, and a decode helper that
// turns an opcode into stack push/pop requests.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [5:0] OP_PUSH = 6'b000101;
  localparam logic [5:0] OP_POP  = 6'b000100;

  typedef struct packed {
    logic push;
    logic pop;
  } stack_req_t;

  function automatic stack_req_t decode_stack_op(input logic [5:0] opcode, input logic en);
    stack_req_t req;
    req.push = en && (opcode == OP_PUSH);
    req.pop  = en && (opcode == OP_POP);
    return req;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// LIFO storage: one synchronous write port and one asynchronous read port.
// Not reset; contents are undefined until written.
module stack_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_lifo_unit.sv
// Return-address stack: LIFO storage with pointer, push/pop handshake,
// registered pop data with one-cycle latency, and sticky error flags.
module stack_lifo_unit #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  input  logic              clr_err,
  output logic              push_ack,
  output logic              pop_ack,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  import cpu_pkg::*;

  localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] OneCnt  = (PTR_W+1)'(1);

  logic [PTR_W:0]    count_q, count_d, count_m1;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              is_empty, is_full;
  logic              push_ok, pop_ok;
  logic [PTR_W-1:0]  waddr;
  logic [DATA_W-1:0] rdata;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);
  assign count_m1 = count_q - OneCnt;

  always_comb begin
    pop_ok  = pop_req && !is_empty;
    // A simultaneous accepted pop frees the top slot, so a full stack still takes the push.
    push_ok = push_req && (!is_full || pop_ok);
    // Replace-top writes over the entry being popped; a plain push writes above it.
    waddr   = pop_ok ? count_m1[PTR_W-1:0] : count_q[PTR_W-1:0];

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + OneCnt;
    end else if (pop_ok && !push_ok) begin
      count_d = count_m1;
    end

    pop_valid_d = pop_ok;
    pop_data_d  = pop_ok ? rdata : pop_data_q;
    // Set wins over clear.
    overflow_d  = (push_req && !push_ok) || (overflow_q && !clr_err);
    underflow_d = (pop_req && !pop_ok) || (underflow_q && !clr_err);
  end

  stack_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_stack_ram (
    .clk_i   (clk),
    .we_i    (push_ok),
    .waddr_i (waddr),
    .wdata_i (push_data),
    .raddr_i (count_m1[PTR_W-1:0]),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign push_ack  = push_ok;
  assign pop_ack   = pop_ok;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_lifo_unit.sv
// Directed bench for stack_lifo_unit with hand-computed expected values.
module tb_stack_lifo_unit;

  logic        clk;
  logic        rst;
  logic        push_req;
  logic [15:0] push_data;
  logic        pop_req;
  logic        clr_err;
  logic        push_ack;
  logic        pop_ack;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int n_cmp;
  int n_err;

  stack_lifo_unit #(
    .DATA_W (16),
    .DEPTH  (16),
    .PTR_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .push_data (push_data),
    .pop_req   (pop_req),
    .clr_err   (clr_err),
    .push_ack  (push_ack),
    .pop_ack   (pop_ack),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] Words [3] = '{16'hA42F, 16'h9BC2, 16'h7D10};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    push_req  = 1'b0;
    push_data = '0;
    pop_req   = 1'b0;
    clr_err   = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_pop_valid", 32'(pop_valid), 32'd0);
    check_eq("rst_pop_data", 32'(pop_data), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_unf", 32'(underflow), 32'd0);

    // Three pushes on consecutive cycles.
    for (int i = 0; i < 3; i++) begin
      push_req  = 1'b1;
      push_data = Words[i];
      #1;
      check_eq("push3_ack", 32'(push_ack), 32'd1);
      step();
    end
    push_req = 1'b0;
    check_eq("push3_count", 32'(count), 32'd3);
    check_eq("push3_empty", 32'(empty), 32'd0);

    // Three back-to-back pops return the words in reverse order.
    pop_req = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      #1;
      check_eq("pop3_ack", 32'(pop_ack), 32'd1);
      step();
      if (i == 0) pop_req = 1'b0;
      check_eq("pop3_valid", 32'(pop_valid), 32'd1);
      check_eq("pop3_data", 32'(pop_data), 32'(Words[i]));
    end
    check_eq("pop3_count", 32'(count), 32'd0);
    check_eq("pop3_empty", 32'(empty), 32'd1);
    step();
    check_eq("pop3_valid_drop", 32'(pop_valid), 32'd0);
    check_eq("pop3_data_hold", 32'(pop_data), 32'hA42F);

    // Underflow, clear, and set-wins-over-clear.
    pop_req = 1'b1;
    #1;
    check_eq("unf_pop_ack", 32'(pop_ack), 32'd0);
    step();
    pop_req = 1'b0;
    check_eq("unf_valid", 32'(pop_valid), 32'd0);
    check_eq("unf_flag", 32'(underflow), 32'd1);
    check_eq("unf_count", 32'(count), 32'd0);
    clr_err = 1'b1;
    step();
    check_eq("unf_cleared", 32'(underflow), 32'd0);
    pop_req = 1'b1;
    step();
    pop_req = 1'b0;
    check_eq("unf_set_wins", 32'(underflow), 32'd1);
    step();
    clr_err = 1'b0;
    check_eq("unf_cleared2", 32'(underflow), 32'd0);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < 16; i++) begin
      push_req  = 1'b1;
      push_data = 16'(i);
      step();
    end
    check_eq("fill_count", 32'(count), 32'd16);
    check_eq("fill_full", 32'(full), 32'd1);
    push_data = 16'h22E4;
    #1;
    check_eq("ovf_push_ack", 32'(push_ack), 32'd0);
    step();
    push_req = 1'b0;
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd16);
    check_eq("ovf_full", 32'(full), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);

    // Replace-top while full: no overflow.
    push_req  = 1'b1;
    push_data = 16'h22E4;
    pop_req   = 1'b1;
    #1;
    check_eq("full_rep_push_ack", 32'(push_ack), 32'd1);
    check_eq("full_rep_pop_ack", 32'(pop_ack), 32'd1);
    step();
    push_req = 1'b0;
    check_eq("full_rep_data", 32'(pop_data), 32'h000F);
    check_eq("full_rep_valid", 32'(pop_valid), 32'd1);
    check_eq("full_rep_count", 32'(count), 32'd16);
    check_eq("full_rep_ovf", 32'(overflow), 32'd0);
    step();
    pop_req = 1'b0;
    check_eq("full_pop_data", 32'(pop_data), 32'h22E4);
    check_eq("full_pop_count", 32'(count), 32'd15);

    // Mid-cycle reset, then build count=2 with 16'h1111 on top.
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    step();
    push_req  = 1'b1;
    push_data = 16'h3333;
    step();
    push_data = 16'h1111;
    step();
    check_eq("rep_pre_count", 32'(count), 32'd2);
    push_data = 16'h2222;
    pop_req   = 1'b1;
    #1;
    check_eq("rep_push_ack", 32'(push_ack), 32'd1);
    check_eq("rep_pop_ack", 32'(pop_ack), 32'd1);
    step();
    push_req = 1'b0;
    check_eq("rep_data", 32'(pop_data), 32'h1111);
    check_eq("rep_count", 32'(count), 32'd2);
    step();
    check_eq("rep_next_data", 32'(pop_data), 32'h2222);
    check_eq("rep_next_count", 32'(count), 32'd1);
    step();
    pop_req = 1'b0;
    check_eq("rep_last_data", 32'(pop_data), 32'h3333);
    check_eq("rep_last_empty", 32'(empty), 32'd1);
    step();

    // Push+pop on empty: push taken, pop rejected.
    push_req  = 1'b1;
    push_data = 16'h5555;
    pop_req   = 1'b1;
    #1;
    check_eq("emp_both_push_ack", 32'(push_ack), 32'd1);
    check_eq("emp_both_pop_ack", 32'(pop_ack), 32'd0);
    step();
    push_req = 1'b0;
    check_eq("emp_both_count", 32'(count), 32'd1);
    check_eq("emp_both_unf", 32'(underflow), 32'd1);
    check_eq("emp_both_valid", 32'(pop_valid), 32'd0);
    step();
    pop_req = 1'b0;
    check_eq("last_pop_valid", 32'(pop_valid), 32'd1);
    check_eq("last_pop_data", 32'(pop_data), 32'h5555);

    // Asynchronous reset in the cycle after the accepted pop.
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 32'(pop_valid), 32'd0);
    check_eq("async_rst_data", 32'(pop_data), 32'd0);
    check_eq("async_rst_count", 32'(count), 32'd0);
    check_eq("async_rst_ovf", 32'(overflow), 32'd0);
    check_eq("async_rst_unf", 32'(underflow), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_lifo_unit.md
Name: stack_lifo_unit

Overview:
- Hardware return-address stack serving the CPU's stack-pointer side.
- The control path issues push (CALL/store) and pop (RET/load) requests. This block holds the LIFO storage and manages its own pointer.
- Returns popped data with fixed one-cycle latency, and reports occupancy and error status back to control.
- Sits between the instruction decode/control unit and the PC-update mux.

Parameters:
- DATA_W, 16, width of each stacked word (matches the 16-bit pc).
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push_req  input  1  request to push push_data this cycle.
- push_data  input  DATA_W  word to push (typically pc+1).
- pop_req  input  1  request to pop the top entry this cycle.
- clr_err  input  1  clears the sticky error flags.
- push_ack  output  1  push accepted this cycle (combinational).
- pop_ack  output  1  pop accepted this cycle (combinational).
- pop_valid  output  1  pop_data valid; registered, one cycle after pop_ack.
- pop_data  output  DATA_W  popped word; registered.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - count=0, pop_valid=0, pop_data=0, overflow=0, underflow=0.
  - Storage array is not reset; its contents are don't-care.
- Internal state is a write pointer wp = count. Top of stack is entry count-1.
- Push only (push_req & !pop_req):
  - If !full: mem[count]<=push_data, count<=count+1, push_ack=1.
  - If full: no write, push_ack=0, overflow<=1.
- Pop only (pop_req & !push_req):
  - If !empty: pop_data<=mem[count-1], pop_valid<=1 next cycle, count<=count-1, pop_ack=1.
  - If empty: pop_ack=0, underflow<=1, pop_valid<=0.
- Push and pop in the same cycle, not empty (includes full):
  - Replace top: pop_data<=old mem[count-1], mem[count-1]<=push_data, count unchanged.
  - Both acks=1, pop_valid<=1. No overflow, even when full.
- Push and pop in the same cycle, empty:
  - Push performed (count becomes 1), push_ack=1.
  - Pop rejected, pop_ack=0, underflow<=1, pop_valid<=0.
- pop_valid:
  - Single-cycle pulse per accepted pop.
  - pop_data holds its last value when pop_valid=0.
  - Back-to-back pops give one valid word per cycle.
- Pointer arithmetic:
  - count is PTR_W+1 bits and never wraps: saturates by rejection at 0 and DEPTH.
  - Storage is addressed with the low PTR_W bits only.
- Sticky errors:
  - Set on the event and held until clr_err.
  - If clr_err coincides with a new error event, the flag stays set (set wins).
- empty and full are combinational from count. They reflect the post-update value on the following cycle.
- Requests are level-sampled each rising edge; there is no request holding or queueing. A rejected request is dropped.
- Reset asserted during a pop: the pending pop_valid is cancelled and no data is presented.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=16.
  - Stack opcodes: OP_PUSH=6'b000101, OP_POP=6'b000100.
  - A decode helper function that maps opcode+enable to push_req/pop_req, for use in the control unit.
- One sub-module, stack_ram: DEPTH x DATA_W, one synchronous write port, one asynchronous read port, no reset.
- The top level holds count, the handshake logic, the error flags and the output registers.

Test Plan:
- Reset, then push 16'hA42F, 16'h9BC2, 16'h7D10 on consecutive cycles -> push_ack=1 each cycle, count=3, empty=0.
- Pop three times back-to-back -> pop_valid pulses on cycles n+1..n+3 with 16'h7D10, 16'h9BC2, 16'hA42F; count=0, empty=1.
- Pop when empty -> pop_ack=0, pop_valid stays 0, underflow=1. Assert clr_err -> underflow=0. Pop while clr_err=1 with the stack still empty -> underflow stays 1.
- Push 16 words 16'h0000..16'h000F, then push 16'h22E4 -> full=1, push_ack=0, overflow=1, count stays 16. Then pop -> 16'h000F.
- With 16'h1111 on top and count=2, assert push(16'h2222) and pop together -> pop_data=16'h1111, count=2. Next pop -> 16'h2222.
- Assert rst asynchronously (mid-cycle) in the cycle after an accepted pop -> pop_valid=0 immediately, count=0, overflow=0, underflow=0.
